// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU op codes, the 4-bit function
// code set, pipeline stage states and the datapath width.
package alu_pkg;

  localparam int DW = 16;

  typedef enum logic [2:0] {
    ALU_ROL = 3'd0,
    ALU_SLL = 3'd1,
    ALU_ROR = 3'd2,
    ALU_SRA = 3'd3,
    ALU_ADD = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_AND = 3'd7
  } alu_op_t;

  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_XOR  = 4'd2,
    FN_ANDN = 4'd3,
    FN_ROL  = 4'd4,
    FN_SLL  = 4'd5,
    FN_ROR  = 4'd6,
    FN_SRA  = 4'd7,
    FN_OR   = 4'd8,
    FN_AND  = 4'd9,
    FN_SEQ  = 4'd10,
    FN_SLT  = 4'd11,
    FN_SLE  = 4'd12,
    FN_SCO  = 4'd13,
    FN_BTR  = 4'd14,
    FN_LBI  = 4'd15
  } func_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_t;

  function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) begin
      r[i] = v[DW-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ALU.sv
// 16-bit combinational ALU: optional operand inversion, add with carry-in,
// logic ops, and rotates/shifts of A by B[3:0].
module ALU
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  alu_op_t       op,
  input  logic          invA,
  input  logic          invB,
  input  logic          sign,
  output logic [DW-1:0] out,
  output logic          ofl,
  output logic          zero
);

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW:0]   sum;
  logic [3:0]    sh;
  logic [4:0]    sh_inv;

  always_comb begin
    op_a   = invA ? ~a : a;
    op_b   = invB ? ~b : b;
    sum    = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, cin};
    sh     = op_b[3:0];
    sh_inv = 5'(DW) - {1'b0, sh};
    out    = '0;
    ofl    = 1'b0;
    case (op)
      ALU_ROL: out = (op_a << sh) | (op_a >> sh_inv);
      ALU_SLL: out = op_a << sh;
      ALU_ROR: out = (op_a >> sh) | (op_a << sh_inv);
      ALU_SRA: out = $signed(op_a) >>> sh;
      ALU_ADD: begin
        out = sum[DW-1:0];
        // Signed: operands agree in sign but the sum does not. Unsigned: carry out.
        ofl = sign ? ((op_a[DW-1] == op_b[DW-1]) && (sum[DW-1] != op_a[DW-1]))
                   : sum[DW];
      end
      ALU_OR:  out = op_a | op_b;
      ALU_XOR: out = op_a ^ op_b;
      ALU_AND: out = op_a & op_b;
      default: out = '0;
    endcase
    zero = (out == '0);
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: S1 holds the decoded request and feeds the ALU/bypass logic,
// S2 registers the result, overflow and zero flag for the writeback mux.
module alu_exec
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_func,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_ofl,
  output logic          out_zero
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload while valid && !ready, and S2 never changes
  // while out_valid && !out_ready.
  stage_t        s1_state_q, s1_state_d;
  stage_t        s2_state_q, s2_state_d;
  func_t         s1_func_q, s1_func_d;
  logic [DW-1:0] s1_a_q, s1_a_d;
  logic [DW-1:0] s1_b_q, s1_b_d;
  logic [DW-1:0] s2_result_q, s2_result_d;
  logic          s2_ofl_q, s2_ofl_d;
  logic          s2_zero_q, s2_zero_d;

  logic          s1_advance;
  logic          in_fire;

  alu_op_t       alu_op;
  logic          alu_inv_a;
  logic          alu_inv_b;
  logic          alu_cin;
  logic          alu_sign;
  logic [DW-1:0] alu_out;
  logic          alu_ofl;
  logic          alu_zero;

  logic          sub_neg;
  logic          a_lt_b;
  logic          a_le_b;
  logic [DW-1:0] sco_wrap;
  logic          sco_carry;
  logic [DW-1:0] ex_result;
  logic          ex_ofl;

  // Decoder: compares run b - a through the SUB path with signed overflow.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_inv_a = 1'b0;
    alu_inv_b = 1'b0;
    alu_cin   = 1'b0;
    alu_sign  = 1'b0;
    case (s1_func_q)
      FN_ADD:  alu_sign = 1'b1;
      FN_SUB, FN_SEQ, FN_SLT, FN_SLE: begin
        alu_inv_a = 1'b1;
        alu_cin   = 1'b1;
        alu_sign  = 1'b1;
      end
      FN_XOR:  alu_op = ALU_XOR;
      FN_ANDN: begin
        alu_op    = ALU_AND;
        alu_inv_b = 1'b1;
      end
      FN_ROL:  alu_op = ALU_ROL;
      FN_SLL:  alu_op = ALU_SLL;
      FN_ROR:  alu_op = ALU_ROR;
      FN_SRA:  alu_op = ALU_SRA;
      FN_OR:   alu_op = ALU_OR;
      FN_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  ALU u_alu (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .cin  (alu_cin),
    .op   (alu_op),
    .invA (alu_inv_a),
    .invB (alu_inv_b),
    .sign (alu_sign),
    .out  (alu_out),
    .ofl  (alu_ofl),
    .zero (alu_zero)
  );

  // The true sign of b - a is the result MSB corrected by overflow.
  always_comb begin
    sub_neg   = alu_out[DW-1] ^ alu_ofl;
    a_lt_b    = !sub_neg && !alu_zero;
    a_le_b    = !sub_neg;
    sco_wrap  = s1_a_q + s1_b_q;
    sco_carry = (sco_wrap < s1_a_q);
    ex_ofl    = 1'b0;
    ex_result = alu_out;
    case (s1_func_q)
      FN_ADD, FN_SUB: ex_ofl = alu_ofl;
      FN_SEQ:  ex_result = {{(DW-1){1'b0}}, alu_zero};
      FN_SLT:  ex_result = {{(DW-1){1'b0}}, a_lt_b};
      FN_SLE:  ex_result = {{(DW-1){1'b0}}, a_le_b};
      FN_SCO:  ex_result = {{(DW-1){1'b0}}, sco_carry};
      FN_BTR:  ex_result = bit_rev(s1_a_q);
      FN_LBI:  ex_result = s1_b_q;
      default: ex_result = alu_out;
    endcase
  end

  always_comb begin
    s1_advance = (s2_state_q == ST_EMPTY) || out_ready;
    in_ready   = (s1_state_q == ST_EMPTY) || s1_advance;
    in_fire    = in_valid && in_ready;

    s1_state_d = s1_state_q;
    s1_func_d  = s1_func_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (in_ready) begin
      s1_state_d = in_valid ? ST_FULL : ST_EMPTY;
    end
    if (in_fire) begin
      s1_func_d = func_t'(in_func);
      s1_a_d    = in_a;
      s1_b_d    = in_b;
    end

    s2_state_d  = s2_state_q;
    s2_result_d = s2_result_q;
    s2_ofl_d    = s2_ofl_q;
    if (s1_advance) begin
      s2_state_d = s1_state_q;
      if (s1_state_q == ST_FULL) begin
        s2_result_d = ex_result;
        s2_ofl_d    = ex_ofl;
      end
    end
    s2_zero_d = (s2_result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state_q  <= ST_EMPTY;
      s2_state_q  <= ST_EMPTY;
      s1_func_q   <= FN_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_result_q <= '0;
      s2_ofl_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
    end else begin
      s1_state_q  <= s1_state_d;
      s2_state_q  <= s2_state_d;
      s1_func_q   <= s1_func_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_result_q <= s2_result_d;
      s2_ofl_q    <= s2_ofl_d;
      s2_zero_q   <= s2_zero_d;
    end
  end

  assign out_valid  = (s2_state_q == ST_FULL);
  assign out_result = s2_result_q;
  assign out_ofl    = s2_ofl_q;
  assign out_zero   = s2_zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed cases with literal results, then randomized
// traffic with random backpressure checked against a behavioural model.
module tb_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_ofl;
  logic        out_zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_res = '0;
  logic        prev_ofl = 1'b0;

  alu_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ofl    (out_ofl),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {ofl, result} straight from the function-code definitions.
  function automatic logic [16:0] model(input logic [3:0] f, input logic [15:0] a,
                                        input logic [15:0] b);
    int          sa;
    int          sb;
    int          s;
    int          n;
    logic [15:0] r;
    logic        o;
    logic [16:0] w;
    sa = $signed(a);
    sb = $signed(b);
    n  = int'(b[3:0]);
    r  = '0;
    o  = 1'b0;
    case (f)
      4'd0: begin
        s = sa + sb;
        r = a + b;
        o = (s > 32767) || (s < -32768);
      end
      4'd1: begin
        s = sb - sa;
        r = b - a;
        o = (s > 32767) || (s < -32768);
      end
      4'd2: r = a ^ b;
      4'd3: r = a & ~b;
      4'd4: r = (n == 0) ? a : ((a << n) | (a >> (16 - n)));
      4'd5: r = a << n;
      4'd6: r = (n == 0) ? a : ((a >> n) | (a << (16 - n)));
      4'd7: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[15], r[15:1]};
      end
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: r = (a == b) ? 16'd1 : 16'd0;
      4'd11: r = (sa < sb) ? 16'd1 : 16'd0;
      4'd12: r = (sa <= sb) ? 16'd1 : 16'd0;
      4'd13: begin
        w = {1'b0, a} + {1'b0, b};
        r = {15'd0, w[16]};
      end
      4'd14: for (int i = 0; i < 16; i++) r[i] = a[15-i];
      default: r = b;
    endcase
    return {o, r};
  endfunction

  // Scoreboard: pop on drain before pushing, since a new request needs two edges.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_result", 32'(out_result), 32'(prev_res));
        check("stall_ofl", 32'(out_ofl), 32'(prev_ofl));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got %0h expected none", out_result);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 32'(out_result), 32'(e[15:0]));
          check("sb_ofl", 32'(out_ofl), 32'(e[16]));
          check("sb_zero", 32'(out_zero), 32'(e[15:0] == 16'd0));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_func, in_a, in_b));
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_ofl   = out_ofl;
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    prev_stall = 1'b0;
  end

  task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_func  = f;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Single request with out_ready high: not valid after the first edge, valid after the second.
  task automatic one_op(input string name, input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic eo);
    @(posedge clk); #1;
    drive(f, a, b);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check({name, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_result"}, 32'(out_result), 32'(er));
    check({name, "_ofl"}, 32'(out_ofl), 32'(eo));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bit          hs;
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_func   = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_ofl", 32'(out_ofl), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    one_op("add_ofl", 4'd0, 16'd20000, 16'd20000, 16'h9C40, 1'b1);
    check("add_zero", 32'(out_zero), 32'd0);
    one_op("sub", 4'd1, 16'h0123, 16'h0234, 16'h0111, 1'b0);
    one_op("seq", 4'd10, 16'h00AA, 16'h00AA, 16'h0001, 1'b0);
    one_op("slt_true", 4'd11, 16'hFFF6, 16'd20, 16'h0001, 1'b0);
    one_op("slt_false", 4'd11, 16'd20, 16'hFFF6, 16'h0000, 1'b0);
    check("slt_false_zero", 32'(out_zero), 32'd1);
    one_op("sle_eq", 4'd12, 16'hFFFB, 16'hFFFB, 16'h0001, 1'b0);
    one_op("sco", 4'd13, 16'd60000, 16'd60000, 16'h0001, 1'b0);

    // Back-to-back: one result per cycle, in order.
    @(posedge clk); #1;
    drive(4'd4, 16'h00EA, 16'd4);
    @(posedge clk); #1;
    drive(4'd7, 16'hFA7B, 16'd4);
    @(posedge clk); #1;
    drive(4'd14, 16'h0001, 16'd0);
    @(negedge clk);
    check("b2b_rol_valid", 32'(out_valid), 32'd1);
    check("b2b_rol", 32'(out_result), 32'h0EA0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("b2b_sra_valid", 32'(out_valid), 32'd1);
    check("b2b_sra", 32'(out_result), 32'hFFA7);
    @(negedge clk);
    check("b2b_btr_valid", 32'(out_valid), 32'd1);
    check("b2b_btr", 32'(out_result), 32'h8000);

    // Backpressure: two accepts fill the pipe, the third waits.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(4'd0, 16'd1, 16'd2);
    @(posedge clk); #1;
    drive(4'd2, 16'h00FF, 16'h0F0F);
    @(posedge clk); #1;
    drive(4'd15, 16'h0000, 16'h1234);
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_result", 32'(out_result), 32'd3);
    repeat (3) begin
      @(negedge clk);
      check("bp_stable", 32'(out_result), 32'd3);
      check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_comb", 32'(in_ready), 32'd1);
    check("bp_first", 32'(out_result), 32'd3);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("bp_second", 32'(out_result), 32'h0FF0);
    @(negedge clk);
    check("bp_third_valid", 32'(out_valid), 32'd1);
    check("bp_third", 32'(out_result), 32'h1234);

    // Reset mid-stream with two requests in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(4'd0, 16'h7FFF, 16'h0001);
    @(posedge clk); #1;
    drive(4'd1, 16'h0001, 16'h0005);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("rst_mid_full", 32'(out_valid), 32'd1);
    check("rst_mid_ofl_before", 32'(out_ofl), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", 32'(out_result), 32'd0);
    check("rst_mid_ofl", 32'(out_ofl), 32'd0);
    check("rst_mid_zero", 32'(out_zero), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic; a pending request is held until accepted.
    hs = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (hs || !in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          f = 4'($urandom_range(0, 15));
          a = pick();
          b = pick();
          if (f >= 4'd10 && f <= 4'd12 && $urandom_range(0, 2) == 0) b = a;
          drive(f, a, b);
        end else begin
          idle();
        end
      end
      @(negedge clk);
      hs = in_valid && in_ready;
    end

    @(posedge clk); #1;
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
